// File: rtl/mem_arb_pkg.sv
// Shared types and block geometry for the unified-memory arbiter and its
// round-robin picker.
package mem_arb_pkg;

  localparam int WORDS_PER_BLOCK   = 8;
  localparam int IDX_W             = 3;
  localparam int BLOCK_OFFSET_BITS = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    I_FILL  = 2'd1,
    D_FILL  = 2'd2,
    D_WRITE = 2'd3
  } arb_state_t;

  typedef enum logic {
    GNT_I = 1'b0,
    GNT_D = 1'b1
  } gnt_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker: on a tie the side that did not win last time
// wins; last_grant only moves when the caller commits a grant.
module rr_arb2
  import mem_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,     // [0] = I side, [1] = D side
  input  logic       update,
  output logic       gnt_valid,
  output gnt_t       gnt
);

  gnt_t last_q;

  always_comb begin
    gnt_valid = |req;
    gnt       = GNT_I;
    if (req == 2'b11) begin
      gnt = (last_q == GNT_I) ? GNT_D : GNT_I;
    end else if (req[1]) begin
      gnt = GNT_D;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      last_q <= GNT_I;
    end else if (update && gnt_valid) begin
      last_q <= gnt;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares the single-ported unified memory between I-cache block fills and
// D-cache block fills / single-word writes.
//
// state   | meaning
// IDLE    | no owner, outputs quiet, arbitrating on sampled requests
// I_FILL  | 8 back-to-back word reads returned to the I side
// D_FILL  | 8 back-to-back word reads returned to the D side
// D_WRITE | one-cycle word write from the D side
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_req,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  output logic                  i_fill_valid,
  output logic [15:0]           i_fill_data,
  output logic [IDX_W-1:0]      i_fill_idx,
  output logic                  i_done,
  input  logic                  d_req,
  input  logic                  d_wr,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [15:0]           d_wdata,
  output logic                  d_fill_valid,
  output logic [15:0]           d_fill_data,
  output logic [IDX_W-1:0]      d_fill_idx,
  output logic                  d_done,
  output logic                  mem_en,
  output logic                  mem_wr,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [15:0]           mem_wdata,
  input  logic [15:0]           mem_rdata,
  output logic                  busy
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS_PER_BLOCK - 1);

  arb_state_t            state_q, state_d;
  logic [IDX_W-1:0]      cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:1] base_q;
  logic [15:0]           wdata_q;
  logic                  grant;
  logic                  arb_valid;
  gnt_t                  arb_gnt;
  logic [IDX_W-1:0]      idx;
  logic [ADDR_WIDTH-1:0] fill_addr;
  logic                  unused_addr_lsb;

  // Byte-lane bit of either request address never reaches the memory.
  assign unused_addr_lsb = i_addr[0] ^ d_addr[0];

  rr_arb2 u_rr_arb2 (
    .clk       (clk),
    .rst       (rst),
    .req       ({d_req, i_req}),
    .update    (grant),
    .gnt_valid (arb_valid),
    .gnt       (arb_gnt)
  );

  // Down-counter runs 7..0; the word index is its complement within the block.
  assign idx       = LAST_IDX - cnt_q;
  assign fill_addr = {base_q[ADDR_WIDTH-1:BLOCK_OFFSET_BITS], idx, 1'b0};

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      base_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (grant) begin
        base_q  <= (arb_gnt == GNT_I) ? i_addr[ADDR_WIDTH-1:1] : d_addr[ADDR_WIDTH-1:1];
        wdata_q <= d_wdata;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    grant        = 1'b0;
    i_fill_valid = 1'b0;
    i_fill_data  = '0;
    i_fill_idx   = '0;
    i_done       = 1'b0;
    d_fill_valid = 1'b0;
    d_fill_data  = '0;
    d_fill_idx   = '0;
    d_done       = 1'b0;
    mem_en       = 1'b0;
    mem_wr       = 1'b0;
    mem_addr     = '0;
    mem_wdata    = '0;
    busy         = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (arb_valid) begin
          grant = 1'b1;
          cnt_d = LAST_IDX;
          if (arb_gnt == GNT_I) begin
            state_d = I_FILL;
          end else begin
            state_d = d_wr ? D_WRITE : D_FILL;
          end
        end
      end

      I_FILL: begin
        busy         = 1'b1;
        mem_en       = 1'b1;
        mem_addr     = fill_addr;
        i_fill_valid = 1'b1;
        i_fill_data  = mem_rdata;
        i_fill_idx   = idx;
        if (cnt_q == '0) begin
          i_done  = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      D_FILL: begin
        busy         = 1'b1;
        mem_en       = 1'b1;
        mem_addr     = fill_addr;
        d_fill_valid = 1'b1;
        d_fill_data  = mem_rdata;
        d_fill_idx   = idx;
        if (cnt_q == '0) begin
          d_done  = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      D_WRITE: begin
        busy      = 1'b1;
        mem_en    = 1'b1;
        mem_wr    = 1'b1;
        mem_addr  = {base_q, 1'b0};
        mem_wdata = wdata_q;
        d_done    = 1'b1;
        state_d   = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: transaction-level schedule model
// compared every cycle, directed scenarios with literal expectations, then random traffic.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        i_req, d_req, d_wr;
  logic [15:0] i_addr, d_addr, d_wdata;
  logic        i_fill_valid, i_done, d_fill_valid, d_done;
  logic [15:0] i_fill_data, d_fill_data;
  logic [2:0]  i_fill_idx, d_fill_idx;
  logic        mem_en, mem_wr, busy;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_WIDTH(16)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr),
    .i_fill_valid(i_fill_valid), .i_fill_data(i_fill_data), .i_fill_idx(i_fill_idx), .i_done(i_done),
    .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_fill_valid(d_fill_valid), .d_fill_data(d_fill_data), .d_fill_idx(d_fill_idx), .d_done(d_done),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  // Memory: never-written word n reads back as n.
  logic [15:0] mem    [0:32767];
  bit          mem_wv [0:32767];
  assign mem_rdata = mem_wv[mem_addr[15:1]] ? mem[mem_addr[15:1]] : {1'b0, mem_addr[15:1]};
  always @(posedge clk) begin
    if (mem_en && mem_wr) begin
      mem[mem_addr[15:1]]    <= mem_wdata;
      mem_wv[mem_addr[15:1]] <= 1'b1;
    end
  end

  logic [15:0] ref_mem [0:32767];
  bit          ref_wv  [0:32767];
  function automatic logic [15:0] ref_rd(input logic [15:0] a);
    return ref_wv[a[15:1]] ? ref_mem[a[15:1]] : {1'b0, a[15:1]};
  endfunction

  typedef struct packed {
    logic        en, wr;
    logic [15:0] addr, wdata;
    logic        ifv;
    logic [15:0] ifd;
    logic [2:0]  ifi;
    logic        idn, dfv;
    logic [15:0] dfd;
    logic [2:0]  dfi;
    logic        ddn, busy;
  } obs_t;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Reference: a queue of expected per-cycle outputs; empty queue = arbiter idle.
  obs_t exp_q[$];
  bit   last_d = 1'b0;

  always @(negedge clk) begin : model
    obs_t        got, exp, e;
    bit          was_idle, pick_d;
    logic [15:0] base;
    got = '{mem_en, mem_wr, mem_addr, mem_wdata, i_fill_valid, i_fill_data, i_fill_idx, i_done,
            d_fill_valid, d_fill_data, d_fill_idx, d_done, busy};
    exp = '0;
    if (exp_q.size() != 0) exp = exp_q[0];
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL cycle_outputs t=%0t: got %h expected %h", $time, got, exp);
    end
    was_idle = (exp_q.size() == 0);
    if (!was_idle) void'(exp_q.pop_front());
    if (!rst) begin
      exp_q.delete();
      last_d = 1'b0;
    end else if (was_idle && (i_req || d_req)) begin
      pick_d = d_req && (!i_req || !last_d);
      last_d = pick_d;
      if (pick_d && d_wr) begin
        e = '0;
        e.en = 1'b1; e.wr = 1'b1; e.busy = 1'b1; e.ddn = 1'b1;
        e.addr = {d_addr[15:1], 1'b0};
        e.wdata = d_wdata;
        exp_q.push_back(e);
        ref_mem[d_addr[15:1]] = d_wdata;
        ref_wv[d_addr[15:1]]  = 1'b1;
      end else begin
        base = pick_d ? {d_addr[15:4], 4'h0} : {i_addr[15:4], 4'h0};
        for (int k = 0; k < 8; k++) begin
          e = '0;
          e.en = 1'b1; e.busy = 1'b1;
          e.addr = base + 16'(2 * k);
          if (pick_d) begin
            e.dfv = 1'b1; e.dfd = ref_rd(e.addr); e.dfi = 3'(k); e.ddn = (k == 7);
          end else begin
            e.ifv = 1'b1; e.ifd = ref_rd(e.addr); e.ifi = 3'(k); e.idn = (k == 7);
          end
          exp_q.push_back(e);
        end
      end
    end
  end

  // Grant-order recorder: which side owns each operation as busy rises.
  bit rec_en = 1'b0;
  bit prev_busy = 1'b0;
  int seq[$];
  always @(negedge clk) begin
    if (rec_en && busy && !prev_busy) seq.push_back((d_fill_valid || d_done) ? 1 : 0);
    prev_busy = busy;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic bit sig(input int which, input int tgt);
    case (which)
      0: return i_done;
      1: return d_done;
      2: return busy;
      3: return i_fill_valid && (i_fill_idx == 3'(tgt));
      4: return d_fill_valid && (d_fill_idx == 3'(tgt));
      default: return i_fill_valid;
    endcase
  endfunction

  task automatic wait_sig(input string name, input int which, input int tgt, input int budget);
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < budget && !ok; n++) begin
      @(negedge clk);
      ok = sig(which, tgt);
    end
    check({"wait_", name}, {31'b0, ok}, 32'd1);
  endtask

  initial begin
    bit ip, dp, idn, ddn;
    i_req = 1'b1; d_req = 1'b1; d_wr = 1'b0;
    i_addr = 16'h0100; d_addr = 16'h0200; d_wdata = 16'h0;

    // reset with both requests held
    @(posedge clk);
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_mem_en", mem_en, 0);
    check("rst_fill_valids", {i_fill_valid, d_fill_valid, i_done, d_done}, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    wait_sig("first_grant", 2, 0, 5);
    check("first_grant_d", {i_fill_valid, d_fill_valid}, 32'b01);
    wait_sig("rst_d_done", 1, 0, 12);
    step(); d_req = 1'b0;
    wait_sig("rst_i_done", 0, 0, 14);
    step(); i_req = 1'b0;
    step();

    // I fill at 0x123A
    i_addr = 16'h123A; i_req = 1'b1;
    wait_sig("ifill_start", 3, 0, 5);
    for (int k = 0; k < 8; k++) begin
      if (k > 0) @(negedge clk);
      check("ifill_addr", mem_addr, 16'h1230 + 16'(2 * k));
      check("ifill_data", i_fill_data, 16'h0918 + 16'(k));
      check("ifill_idx", i_fill_idx, k);
      check("ifill_done", i_done, (k == 7));
      check("ifill_busy", busy, 1);
    end
    step(); i_req = 1'b0;
    @(negedge clk);
    check("ifill_idle_after", busy, 0);
    step();

    // D write then readback
    d_addr = 16'h0041; d_wdata = 16'hBEEF; d_wr = 1'b1; d_req = 1'b1;
    wait_sig("dwr_done", 1, 0, 5);
    check("dwr_en_wr", {mem_en, mem_wr}, 32'b11);
    check("dwr_addr", mem_addr, 16'h0040);
    check("dwr_data", mem_wdata, 16'hBEEF);
    step(); d_req = 1'b0; d_wr = 1'b0;
    step();
    d_addr = 16'h0040; d_req = 1'b1;
    wait_sig("rb_start", 4, 0, 5);
    check("rb_word0", d_fill_data, 16'hBEEF);
    wait_sig("rb_done", 1, 0, 10);
    step(); d_req = 1'b0;
    step();

    // contention after reset
    rst = 1'b0; i_req = 1'b1; d_req = 1'b1; i_addr = 16'h3000; d_addr = 16'h4008; d_wr = 1'b0;
    step();
    rst = 1'b1; seq.delete(); rec_en = 1'b1;
    repeat (38) step();
    i_req = 1'b0; d_req = 1'b0;
    repeat (12) step();
    rec_en = 1'b0;
    check("cont_ops", {31'b0, seq.size() >= 4}, 1);
    if (seq.size() >= 4) begin
      check("cont_g0", seq[0], 1);
      check("cont_g1", seq[1], 0);
      check("cont_g2", seq[2], 1);
      check("cont_g3", seq[3], 0);
    end

    // reset during fill word 4
    i_addr = 16'h2000; i_req = 1'b1;
    wait_sig("mid_w3", 3, 3, 6);
    step(); rst = 1'b0; i_req = 1'b0;
    @(negedge clk);
    check("mid_at_w4", i_fill_idx, 4);
    step();
    @(negedge clk);
    check("mid_rst_quiet", {busy, mem_en, i_fill_valid, i_done}, 0);
    step(); rst = 1'b1; i_req = 1'b1;
    wait_sig("mid_restart", 5, 0, 5);
    check("mid_restart_idx", i_fill_idx, 0);
    check("mid_restart_addr", mem_addr, 16'h2000);
    wait_sig("mid_done", 0, 0, 10);
    step(); i_req = 1'b0;
    step();

    // early drop at word 2, top-of-memory block
    i_addr = 16'hFFF6; i_req = 1'b1;
    wait_sig("drop_w1", 3, 1, 6);
    step(); i_req = 1'b0;
    wait_sig("drop_done", 0, 0, 10);
    check("drop_last_idx", i_fill_idx, 7);
    check("drop_last_addr", mem_addr, 16'hFFFE);
    @(negedge clk);
    check("drop_idle", busy, 0);
    repeat (3) step();

    // random traffic obeying the request protocol
    ip = 1'b0; dp = 1'b0;
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      idn = i_done; ddn = d_done;
      @(posedge clk); #1;
      rst = ($urandom_range(0, 249) != 0);
      if (ip && idn) begin
        i_req = 1'b0; ip = 1'b0;
      end else if (!ip && $urandom_range(0, 2) == 0) begin
        i_req = 1'b1; ip = 1'b1;
        i_addr = ($urandom_range(0, 7) == 0) ? 16'($urandom) : 16'($urandom_range(0, 511));
      end
      if (dp && ddn) begin
        d_req = 1'b0; dp = 1'b0;
      end else if (!dp && $urandom_range(0, 2) == 0) begin
        d_req = 1'b1; dp = 1'b1;
        d_wr = 1'($urandom_range(0, 1));
        d_wdata = 16'($urandom);
        d_addr = ($urandom_range(0, 7) == 0) ? 16'($urandom) : 16'($urandom_range(0, 511));
      end
    end
    rst = 1'b1; i_req = 1'b0; d_req = 1'b0;
    repeat (20) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, compared %0d mismatched %0d", n_cmp, n_bad);
    $fatal(1);
  end

endmodule
